// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-net datapath.
// Retargeting to fixed point means changing only elem_t.
package nn_pkg;

  typedef real elem_t;

  function automatic int flat_idx(input int row, input int col, input int ncols);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/matrix_dot_product_row_col.sv
// Combinational dot product of one row of A with one column of B.
// The terms are accumulated in ascending k, starting from 0.0.
module dot_product_row_col
  import nn_pkg::*;
#(
  parameter int n = 2
) (
  input  elem_t row [n],
  input  elem_t col [n],
  output elem_t sum
);

  elem_t w_acc;

  always_comb begin
    w_acc = 0.0;
    for (int k = 0; k < n; k++) begin
      w_acc = w_acc + row[k] * col[k];
    end
  end

  assign sum = w_acc;

endmodule

// File: rtl/matrix_dot_product.sv
// Registered matrix multiply C = A x B on row-major flattened arrays, one cycle latency.
// Results are cleared asynchronously by rst; outputs come only from registers.
module matrix_dot_product
  import nn_pkg::*;
#(
  parameter int m1 = 2,
  parameter int n1 = 2,
  parameter int m2 = 2,
  parameter int n2 = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  elem_t matrix_a      [m1*n1],
  input  elem_t matrix_b      [m2*n2],
  output elem_t result_matrix [m1*n2]
);

  generate
    if (n1 != m2) begin : g_bad_dims
      $fatal(1, "matrix_dot_product: n1 (%0d) must equal m2 (%0d)", n1, m2);
    end
  endgenerate

  elem_t w_sum    [m1*n2];
  elem_t r_result [m1*n2];

  // One dot-product unit per output element; B columns are gathered with stride n2.
  for (genvar i = 0; i < m1; i++) begin : g_row
    for (genvar j = 0; j < n2; j++) begin : g_col
      elem_t w_row [n1];
      elem_t w_col [n1];

      for (genvar k = 0; k < n1; k++) begin : g_k
        assign w_row[k] = matrix_a[flat_idx(i, k, n1)];
        assign w_col[k] = matrix_b[flat_idx(k, j, n2)];
      end

      dot_product_row_col #(
        .n (n1)
      ) u_dot (
        .row (w_row),
        .col (w_col),
        .sum (w_sum[flat_idx(i, j, n2)])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < m1*n2; e++) begin
        r_result[e] <= 0.0;
      end
    end else begin
      for (int e = 0; e < m1*n2; e++) begin
        r_result[e] <= w_sum[e];
      end
    end
  end

  assign result_matrix = r_result;

endmodule

// File: tb/tb_matrix_dot_product.sv
// Directed bench for matrix_dot_product: a 2x2 instance and a 2x3 * 3x1 instance.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_matrix_dot_product;

  logic clk;
  logic rst;
  real  a    [4];
  real  b    [4];
  real  res  [4];
  real  a2   [6];
  real  b2   [3];
  real  res2 [2];

  int n_tests;
  int n_fail;

  matrix_dot_product #(
    .m1 (2), .n1 (2), .m2 (2), .n2 (2)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .matrix_a      (a),
    .matrix_b      (b),
    .result_matrix (res)
  );

  matrix_dot_product #(
    .m1 (2), .n1 (3), .m2 (3), .n2 (1)
  ) u_dut_ns (
    .clk           (clk),
    .rst           (rst),
    .matrix_a      (a2),
    .matrix_b      (b2),
    .result_matrix (res2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    real exp [4];
    exp = '{0.0, 0.0, 0.0, 0.0};
    rst = 1'b1;
    a   = '{3.0, 3.0, 3.0, 3.0};
    b   = '{3.0, 3.0, 3.0, 3.0};
    repeat (2) @(posedge clk);
    #1;
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    real exp [4];
    @(negedge clk);
    a = '{1.0, 2.0, 3.0, 4.0};
    b = '{1.0, 2.0, 3.0, 4.0};
    @(posedge clk);
    #1;
    exp = '{7.0, 10.0, 15.0, 22.0};
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL basic[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
  endtask

  task automatic test_identity();
    real exp [4];
    @(negedge clk);
    a = '{1.0, 0.0, 0.0, 1.0};
    b = '{5.5, -2.0, 3.25, 8.0};
    #1;
    // still the previous product: no combinational path to the output
    exp = '{7.0, 10.0, 15.0, 22.0};
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL identity_pre_edge[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
    @(posedge clk);
    #1;
    exp = '{5.5, -2.0, 3.25, 8.0};
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL identity[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
  endtask

  task automatic test_async_reset();
    real exp [4];
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp = '{0.0, 0.0, 0.0, 0.0};
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
    a = '{1.0, 2.0, 3.0, 4.0};
    b = '{1.0, 2.0, 3.0, 4.0};
    repeat (2) @(posedge clk);
    #1;
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL reset_across_edges[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL release_pre_edge[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
    @(posedge clk);
    #1;
    exp = '{7.0, 10.0, 15.0, 22.0};
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL first_after_release[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
  endtask

  task automatic test_back_to_back();
    real exp [4];
    @(negedge clk);
    a = '{2.0, 0.0, 0.0, 2.0};
    b = '{1.0, 2.0, 3.0, 4.0};
    @(posedge clk);
    #1;
    exp = '{2.0, 4.0, 6.0, 8.0};
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL b2b_0[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
    @(negedge clk);
    a = '{1.0, 2.0, 3.0, 4.0};
    b = '{0.5, -1.0, 2.0, 0.25};
    @(posedge clk);
    #1;
    // [1 2;3 4] x [0.5 -1;2 0.25]
    exp = '{4.5, -0.5, 9.5, -2.0};
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL b2b_1[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
    @(negedge clk);
    a = '{1.0, 2.0, 3.0, 4.0};
    b = '{1.0, 2.0, 3.0, 4.0};
    @(posedge clk);
    #1;
    exp = '{7.0, 10.0, 15.0, 22.0};
    for (int e = 0; e < 4; e++) begin
      n_tests++;
      if (res[e] != exp[e]) begin
        n_fail++;
        $display("FAIL b2b_2[%0d]: got %f expected %f", e, res[e], exp[e]);
      end
    end
  endtask

  task automatic test_non_square();
    real exp [2];
    @(negedge clk);
    a2 = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0};
    b2 = '{1.0, 1.0, 1.0};
    @(posedge clk);
    #1;
    exp = '{6.0, 15.0};
    for (int e = 0; e < 2; e++) begin
      n_tests++;
      if (res2[e] != exp[e]) begin
        n_fail++;
        $display("FAIL non_square_ones[%0d]: got %f expected %f", e, res2[e], exp[e]);
      end
    end
    @(negedge clk);
    b2 = '{1.0, 0.0, -1.0};
    @(posedge clk);
    #1;
    exp = '{-2.0, -2.0};
    for (int e = 0; e < 2; e++) begin
      n_tests++;
      if (res2[e] != exp[e]) begin
        n_fail++;
        $display("FAIL non_square_diff[%0d]: got %f expected %f", e, res2[e], exp[e]);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    a2      = '{0.0, 0.0, 0.0, 0.0, 0.0, 0.0};
    b2      = '{0.0, 0.0, 0.0};
    test_reset();
    test_basic();
    test_identity();
    test_async_reset();
    test_back_to_back();
    test_non_square();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
